// File: rtl/knight_rider_scanner.sv
// -----------------------------------------------------------------------------
// knight_rider_scanner
//
// One lit LED sweeps across an LED bank. A clock divider sets the sweep rate.
// The sweep either bounces end-to-end (mode = 0) or wraps around (mode = 1).
// Each press of the OnOff push button toggles between scanning and idle.
//
// Parameters
//   LEDS : number of LEDs driven (2..32)
//   DIV  : CLK cycles per scan step (>= 4)
//   CW   : divider counter width (2^CW > DIV)
//
// Ports
//   CLK       in   board clock, rising-edge active
//   clr       in   asynchronous active-low reset
//   OnOff     in   asynchronous push button, pressed = 0
//   mode      in   0 = bounce, 1 = wrap (sampled on step ticks only)
//   LEDRArray out  LED drive, registered
//   running   out  high while scanning
//   step      out  one-cycle pulse per scan step
//
// Optional feature
//   KRS_TRAIL_EN : when defined, the previous head position is driven at 25%
//                  duty (high when cnt[1:0] == 2'b00) behind the lit head.
// -----------------------------------------------------------------------------
module knight_rider_scanner #(
  parameter int LEDS = 10,
  parameter int DIV  = 5000000,
  parameter int CW   = 32
) (
  input  logic            CLK,
  input  logic            clr,
  input  logic            OnOff,
  input  logic            mode,
  output logic [LEDS-1:0] LEDRArray,
  output logic            running,
  output logic            step
);

  localparam int PW = (LEDS > 1) ? $clog2(LEDS) : 1;
  localparam logic [PW-1:0]   POS_MAX  = PW'(LEDS - 1);
  localparam logic [PW-1:0]   POS_ONE  = PW'(1);
  localparam logic [PW-1:0]   POS_ZERO = PW'(0);
  localparam logic [CW-1:0]   CNT_MAX  = CW'(DIV - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);
  localparam logic [LEDS-1:0] LED_ONE  = LEDS'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SCAN_UP   = 2'd1,
    SCAN_DOWN = 2'd2
  } state_e;

  // Button synchroniser chain and registered falling-edge pulse.
  logic sync1_q, sync2_q, sync3_q, fall_q;

  state_e          state_q, state_d;
  logic            dir_up_q, dir_up_d;   // direction to resume with from IDLE
  logic [PW-1:0]   pos_q, pos_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            step_q, step_d;
  logic [LEDS-1:0] led_q, led_d;
  logic            run_s;

  assign run_s     = (state_q != IDLE);
  assign running   = run_s;
  assign step      = step_q;
  assign LEDRArray = led_q;

  // Synchronise the button and register a one-cycle pulse per press.
  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      sync3_q <= 1'b1;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= OnOff;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      fall_q  <= sync3_q & ~sync2_q;
    end
  end

  // Next-state logic: run toggle, divider and position update.
  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    if (fall_q) begin
      // A toggle beats a coincident step: no move, divider restarts.
      cnt_d = CNT_ZERO;
      if (run_s) begin
        state_d = IDLE;
      end else begin
        state_d = dir_up_q ? SCAN_UP : SCAN_DOWN;
      end
    end else if (run_s) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d  = CNT_ZERO;
        step_d = 1'b1;
        if (mode) begin
          state_d = SCAN_UP;
          pos_d   = (pos_q == POS_MAX) ? POS_ZERO : pos_q + POS_ONE;
        end else begin
          case (state_q)
            SCAN_UP: begin
              if (pos_q == POS_MAX) begin
                state_d = SCAN_DOWN;
                pos_d   = POS_MAX - POS_ONE;
              end else begin
                pos_d = pos_q + POS_ONE;
              end
            end
            SCAN_DOWN: begin
              if (pos_q == POS_ZERO) begin
                state_d = SCAN_UP;
                pos_d   = POS_ONE;
              end else begin
                pos_d = pos_q - POS_ONE;
              end
            end
            default: begin
              state_d = IDLE;
            end
          endcase
        end
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = CNT_ZERO;
    end
  end

  // Remember the latest scan direction so a resume continues the same way.
  always_comb begin
    dir_up_d = dir_up_q;
    case (state_d)
      SCAN_UP:   dir_up_d = 1'b1;
      SCAN_DOWN: dir_up_d = 1'b0;
      default:   dir_up_d = dir_up_q;
    endcase
  end

  // State, direction, position, divider and step pulse registers.
  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) begin
      state_q  <= IDLE;
      dir_up_q <= 1'b1;
      pos_q    <= POS_ZERO;
      cnt_q    <= CNT_ZERO;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      step_q   <= step_d;
    end
  end

`ifdef KRS_TRAIL_EN
  logic [PW-1:0] prev_q;
  logic          trail_vld_q;

  // Capture the position left behind by each step.
  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) begin
      prev_q      <= POS_ZERO;
      trail_vld_q <= 1'b0;
    end else if (step_d) begin
      prev_q      <= pos_q;
      trail_vld_q <= 1'b1;
    end else begin
      prev_q      <= prev_q;
      trail_vld_q <= trail_vld_q;
    end
  end

  // LED image: head one-hot plus a 25%-duty trail; head bit always wins.
  always_comb begin
    led_d = '0;
    if (run_s) begin
      led_d = LED_ONE << pos_q;
      if (trail_vld_q && (cnt_q[1:0] == 2'b00)) begin
        led_d = led_d | (LED_ONE << prev_q);
      end else begin
        led_d = led_d;
      end
    end else begin
      led_d = '0;
    end
  end
`else
  // LED image: strictly one-hot at the head while scanning, dark when idle.
  always_comb begin
    led_d = '0;
    if (run_s) begin
      led_d = LED_ONE << pos_q;
    end else begin
      led_d = '0;
    end
  end
`endif

  // Registered LED drive.
  always_ff @(posedge CLK or negedge clr) begin
    if (!clr) begin
      led_q <= '0;
    end else begin
      led_q <= led_d;
    end
  end

endmodule

// File: tb/tb_knight_rider_scanner.sv
module tb_knight_rider_scanner;

  localparam int L = 4;
  localparam int D = 4;

  logic         CLK;
  logic         clr;
  logic         OnOff;
  logic         mode;
  logic [L-1:0] LEDRArray;
  logic         running;
  logic         step;

  int n_checks = 0;
  int n_fail   = 0;

  knight_rider_scanner #(.LEDS(L), .DIV(D), .CW(8)) dut (
    .CLK       (CLK),
    .clr       (clr),
    .OnOff     (OnOff),
    .mode      (mode),
    .LEDRArray (LEDRArray),
    .running   (running),
    .step      (step)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- behavioural reference model ----------------
  // Position is tracked as a phase around the bounce cycle:
  // phase 0..L-1 climbs, phase L..2(L-1)-1 descends.
  bit           m_hist [4];   // pin samples at the last four edges, oldest first
  bit           m_run;
  int           m_phase;
  int           m_elapsed;
  bit           m_step;
  logic [L-1:0] m_led;
  bit           m_tg;

  function automatic int pos_of(int ph);
    return (ph < L) ? ph : 2 * (L - 1) - ph;
  endfunction

  always @(posedge CLK or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 4; i++) m_hist[i] = 1'b1;
      m_run     = 1'b0;
      m_phase   = 0;
      m_elapsed = 0;
      m_step    = 1'b0;
      m_led     = '0;
    end else begin
      m_tg = m_hist[0] & ~m_hist[1];
      m_hist[0] = m_hist[1];
      m_hist[1] = m_hist[2];
      m_hist[2] = m_hist[3];
      m_hist[3] = OnOff;
      m_led  = m_run ? L'(1 << pos_of(m_phase)) : '0;
      m_step = 1'b0;
      if (m_tg) begin
        m_run     = ~m_run;
        m_elapsed = 0;
      end else if (m_run) begin
        m_elapsed++;
        if (m_elapsed == D) begin
          m_elapsed = 0;
          m_step    = 1'b1;
          if (mode) m_phase = (pos_of(m_phase) + 1) % L;
          else      m_phase = (m_phase + 1) % (2 * (L - 1));
        end
      end else begin
        m_elapsed = 0;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance to the next falling edge and compare the DUT with the model.
  task automatic tick();
    @(negedge CLK);
    if (clr) begin
      chk("model_led", 32'(LEDRArray), 32'(m_led));
      chk("model_running", 32'(running), 32'(m_run));
      chk("model_step", 32'(step), 32'(m_step));
    end
  endtask

  task automatic wait_step();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      tick();
      if (step === 1'b1) seen = 1'b1;
    end
    if (!seen) chk("step_timeout", 32'd0, 32'd1);
  endtask

  // Press from idle: running must rise exactly four edges after the pin falls.
  task automatic press_start(input logic [L-1:0] exp_led);
    OnOff = 1'b0;
    tick();
    tick();
    OnOff = 1'b1;
    tick();
    chk("press_latency_lo", 32'(running), 32'd0);
    tick();
    chk("press_latency_hi", 32'(running), 32'd1);
    tick();
    chk("press_first_led", 32'(LEDRArray), 32'(exp_led));
  endtask

  logic [L-1:0] bounce_seq [9] = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010,
                                   4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [L-1:0] wrap_seq   [6] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100};

  initial begin
    OnOff = 1'b1;
    mode  = 1'b0;
    clr   = 1'b0;

    // Reset state
    repeat (3) @(negedge CLK);
    chk("reset_led", 32'(LEDRArray), 32'd0);
    chk("reset_running", 32'(running), 32'd0);
    chk("reset_step", 32'(step), 32'd0);
    clr = 1'b1;
    repeat (100) tick();
    chk("idle_no_press", 32'(LEDRArray), 32'd0);

    // Bounce sweep
    press_start(4'b0001);
    for (int i = 0; i < 9; i++) begin
      wait_step();
      tick();
      chk("bounce_seq", 32'(LEDRArray), 32'(bounce_seq[i]));
    end

    // Stop at pos 2 descending, press edge lands on the would-be step cycle
    wait_step();
    OnOff = 1'b0;
    tick();
    chk("stop_pos_before", 32'(LEDRArray), 32'(4'b0100));
    tick();
    tick();
    OnOff = 1'b1;
    tick();
    chk("collision_running", 32'(running), 32'd0);
    chk("collision_no_step", 32'(step), 32'd0);
    tick();
    chk("stopped_led", 32'(LEDRArray), 32'd0);
    repeat (10) tick();
    chk("stopped_quiet", 32'(step), 32'd0);

    // Resume continues downward from the same position
    press_start(4'b0100);
    wait_step();
    tick();
    chk("resume_next", 32'(LEDRArray), 32'(4'b0010));

    // Asynchronous clear mid-scan
    tick();
    #2 clr = 1'b0;
    #1;
    chk("async_clr_led", 32'(LEDRArray), 32'd0);
    chk("async_clr_running", 32'(running), 32'd0);
    @(negedge CLK);
    mode = 1'b1;
    clr  = 1'b1;
    repeat (20) tick();
    chk("post_clr_idle", 32'(LEDRArray), 32'd0);

    // Wrap sweep, then switch to bounce while at 0100
    press_start(4'b0001);
    for (int i = 0; i < 6; i++) begin
      wait_step();
      tick();
      chk("wrap_seq", 32'(LEDRArray), 32'(wrap_seq[i]));
    end
    mode = 1'b0;
    wait_step();
    tick();
    chk("mode_switch_1", 32'(LEDRArray), 32'(4'b1000));
    wait_step();
    tick();
    chk("mode_switch_2", 32'(LEDRArray), 32'(4'b0100));

    // Randomised presses, mode flips and occasional clears against the model
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 24) == 0) OnOff = ~OnOff;
      if ($urandom_range(0, 39) == 0) mode = ~mode;
      if ($urandom_range(0, 599) == 0) begin
        clr = 1'b0;
        tick();
        clr = 1'b1;
      end
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/knight_rider_scanner.md
# knight_rider_scanner

Parametrised Knight Rider LED scanner: one lit LED sweeps across an LED bank at a rate set by an internal clock divider. The scanner bounces end-to-end or wraps around, and a push button starts and stops it. It sits between the board clock/KEY inputs and the LEDR bank, and replaces the ad-hoc toggle/divider/counter chain with a single synchronous block.

## Interface
- `LEDS`, default 10: number of LEDs driven; legal range 2..32.
- `DIV`, default 5000000: CLK cycles per scan step; must be ≥ 4.
- `CW`, default 32: divider counter width; must satisfy `2^CW > DIV`.

- `CLK`, input, 1: board clock (50 MHz); all state updates on rising edge.
- `clr`, input, 1: one clock; reset is asynchronous and active-low.
- `OnOff`, input, 1: asynchronous push button, normally high (pressed = 0); each press toggles run/stop.
- `mode`, input, 1: 0 = bounce, 1 = wrap; sampled only on step ticks.
- `LEDRArray`, output, LEDS: LED drive, registered.
- `running`, output, 1: high while scanning.
- `step`, output, 1: one-cycle pulse on each scan step.

## Operation
- **Input sync:** `OnOff` passes through a 2-flop synchroniser, then a registered falling-edge detect. Each detected falling edge toggles `run`. There is no debounce; the board supplies a debounced KEY.
- **Divider:** `cnt` (CW bits) increments while `run` = 1. When `cnt == DIV-1`, `cnt` goes to 0 and `step` pulses for one cycle. While `run` = 0, `cnt` is held at 0.
- **States:** IDLE, SCAN_UP, SCAN_DOWN. `pos` is a position register (0..LEDS-1).
  - IDLE → previous scan state on a run toggle. Reset enters IDLE with a remembered direction of UP.
  - SCAN_x → IDLE on a run toggle. `pos` and direction are retained, so the scan resumes where it stopped.
- **On step, bounce (`mode` = 0):**
  - SCAN_UP: if `pos == LEDS-1`, go to SCAN_DOWN with `pos = LEDS-2`; else `pos+1`.
  - SCAN_DOWN: if `pos == 0`, go to SCAN_UP with `pos = 1`; else `pos-1`.
- **On step, wrap (`mode` = 1):**
  - Direction is forced to SCAN_UP.
  - `pos = (pos == LEDS-1) ? 0 : pos+1`.
  - From SCAN_DOWN, the first wrap step is the same `pos+1` move.
- **Output:** `LEDRArray` is one-hot at `pos` while `running`, and all zeros in IDLE.
- **Simultaneous events:** a run toggle in the same cycle as a would-be step wins. No step is taken and `cnt` clears.

## Timing
- **Reset values:** `LEDRArray` = 0, `running` = 0, `step` = 0, `pos` = 0, `cnt` = 0, state = IDLE, sync flops = 1.
- **Press latency:** 4 cycles from the `OnOff` falling edge at the pin to `running` rising (2 sync + 1 edge detect + 1 state register).
- **LED latency:** `LEDRArray` updates in the cycle after `running` changes, and in the cycle after `step`.
- **Step timing:**
  - First step occurs `DIV` cycles after `running` rises.
  - Subsequent steps occur every `DIV` cycles.
  - A full bounce period is `2·(LEDS-1)·DIV` cycles; a full wrap period is `LEDS·DIV` cycles.
- **Reset during a scan:** `clr` asserted mid-scan clears everything immediately (asynchronously). After `clr` deasserts, the block stays in IDLE until a press.
- **Mode change:** a change of `mode` mid-step takes effect at the next step only.

## Configuration
- **`KRS_TRAIL_EN` defined:** the LED at the previous position (the `pos` before the last step) is driven at 25% duty, high when `cnt[1:0] == 2'b00`. The trail is suppressed in IDLE and before the first step after reset. The lit head LED overrides the trail.
- **`KRS_TRAIL_EN` undefined:** strictly one-hot output and no trail register.

## Test plan
- **Reset:** `clr` = 0 for 3 cycles → all outputs 0, state IDLE. Release `clr` and give no press for 100 cycles → `LEDRArray` stays 0.
- **Bounce sweep** (LEDS=4, DIV=4, `mode`=0): press once → after 4 cycles `LEDRArray` = 0001. Then every 4 cycles the sequence is 0010, 0100, 1000, 0100, 0010, 0001, 0010.
- **Wrap:** same setup with `mode`=1 → sequence 0001, 0010, 0100, 1000, 0001. Switch `mode` 1→0 while at 0100 → next steps 1000 then 0100.
- **Stop/resume:** press at `pos`=2 in SCAN_DOWN → `LEDRArray` = 0000 within 5 cycles and `step` silent. Press again → 0100 reappears, then 0010 `DIV` cycles later.
- **Collision and reset:** a press edge timed onto the `cnt == DIV-1` cycle → no `step` pulse and `pos` unchanged. Assert `clr` mid-scan → `LEDRArray` = 0 asynchronously, before the next CLK edge.
- **Trail** (`KRS_TRAIL_EN`, LEDS=4, DIV=4): after the 0001→0010 step, bit 0 is high exactly 1 of every 4 cycles and bit 1 is constantly high.
